regfile_wb: RTL and testbench

- 32 x 32-bit MIPS general register file.
- Consumer of the 5-bit write-destination address produced by the decode-stage destination selector (rt / rd / $31).
- Provides one synchronous write port (write-back stage) and two combinational read ports (decode stage).
- Keeps a per-register "written since reset" valid mask and a write counter for simulation-time checking.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/regfile_rd_port.sv | 35 +++
 rtl/regfile_wb.sv | 76 +++++++
 tb/tb_regfile_wb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions for the decode / write-back datapath.
//   REG_ZERO / REG_RA : architectural register numbers ($0, $31)
//   regdst_e          : destination-selector encoding (rt / rd / $31 / none)
//   DATA_W_DEF/ADDR_W_DEF : default register-file geometry
//   regdst_addr()     : destination-register mux used by the decode stage
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_NONE = 2'b11
    } regdst_e;

    function automatic logic [4:0] regdst_addr(input regdst_e sel,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        logic [4:0] a;
        case (sel)
            REGDST_RT: a = rt;
            REGDST_RD: a = rd;
            REGDST_RA: a = REG_RA;
            default:   a = REG_ZERO;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
//   i_rd_addr  : read address
//   i_reg_data : storage contents at i_rd_addr
//   i_wr_en/i_wr_addr/i_wr_data : write-back port (only with REGFILE_WB_BYPASS_EN)
//   o_rd_data  : read data; $0 always returns zero
// Macro REGFILE_WB_BYPASS_EN enables write-first forwarding of the
// in-flight write-back value onto this port.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_reg_data,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
`endif
    output logic [DATA_W-1:0] o_rd_data
);

    always_comb begin
        o_rd_data = i_reg_data;
`ifdef REGFILE_WB_BYPASS_EN
        if (i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr))
            o_rd_data = i_wr_data;
`endif
        // Zero masking last so $0 reads zero even under forwarding.
        if (i_rd_addr == '0)
            o_rd_data = '0;
    end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: MIPS general register file, one synchronous write port
// (write-back) and two combinational read ports (decode).
//   CLK, Reset           : clock, asynchronous active-high reset
//   WrEn/WrAddr/WrData   : write-back port; writes to $0 are discarded
//   RdAddrA/B, RdDataA/B : combinational read ports
//   ValidMask            : bit i set once register i written since reset (bit 0 always set)
//   WrCount              : committed writes since reset, wraps modulo 2**CNT_W
// Macro REGFILE_WB_BYPASS_EN: write-first forwarding on both read ports.
module regfile_wb
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 WrEn,
    input  logic [ADDR_W-1:0]    WrAddr,
    input  logic [DATA_W-1:0]    WrData,
    input  logic [ADDR_W-1:0]    RdAddrA,
    input  logic [ADDR_W-1:0]    RdAddrB,
    output logic [DATA_W-1:0]    RdDataA,
    output logic [DATA_W-1:0]    RdDataB,
    output logic [2**ADDR_W-1:0] ValidMask,
    output logic [CNT_W-1:0]     WrCount
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [CNT_W-1:0]  r_count;
    logic              w_commit;

    assign w_commit = WrEn && (WrAddr != '0);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_valid <= {{(DEPTH-1){1'b0}}, 1'b1};
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[WrAddr]  <= WrData;
            r_valid[WrAddr] <= 1'b1;
            r_count         <= r_count + CNT_W'(1);
        end
    end

    assign ValidMask = r_valid;
    assign WrCount   = r_count;

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .i_rd_addr  (RdAddrA),
        .i_reg_data (r_regs[RdAddrA]),
`ifdef REGFILE_WB_BYPASS_EN
        .i_wr_en    (WrEn),
        .i_wr_addr  (WrAddr),
        .i_wr_data  (WrData),
`endif
        .o_rd_data  (RdDataA)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .i_rd_addr  (RdAddrB),
        .i_reg_data (r_regs[RdAddrB]),
`ifdef REGFILE_WB_BYPASS_EN
        .i_wr_en    (WrEn),
        .i_wr_addr  (WrAddr),
        .i_wr_data  (WrData),
`endif
        .o_rd_data  (RdDataB)
    );

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    localparam int CW = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        WrEn = 1'b0;
    logic [4:0]  WrAddr = '0;
    logic [31:0] WrData = '0;
    logic [4:0]  RdAddrA = '0;
    logic [4:0]  RdAddrB = '0;
    logic [31:0] RdDataA, RdDataB;
    logic [31:0] ValidMask;
    logic [CW-1:0] WrCount;

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(RdDataA), .RdDataB(RdDataB),
        .ValidMask(ValidMask), .WrCount(WrCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic [31:0] mask;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic strobe = 1'b0;

    // Reference model: architectural state only.
    logic [31:0] mem [32];
    logic [31:0] m_mask;
    int          m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        m_mask = 32'h1;
        m_cnt  = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) return wd;
`endif
        return mem[a];
    endfunction

    task automatic push_check(input string tag);
        exp_t e;
        e.tag  = tag;
        e.rda  = model_read(RdAddrA, WrEn, WrAddr, WrData);
        e.rdb  = model_read(RdAddrB, WrEn, WrAddr, WrData);
        e.mask = m_mask;
        e.cnt  = m_cnt;
        q.push_back(e);
        strobe = 1'b1;
        #1 strobe = 1'b0;
    endtask

    // One cycle: drive after negedge, check pre-edge view, update model at posedge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input string tag);
        @(negedge CLK);
        WrEn = we; WrAddr = wa; WrData = wd; RdAddrA = ra; RdAddrB = rb;
        #1 push_check(tag);
        @(posedge CLK);
        if (we && wa != 5'd0) begin
            mem[wa]    = wd;
            m_mask[wa] = 1'b1;
            m_cnt      = (m_cnt + 1) % (1 << CW);
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge strobe);
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                e = q.pop_front();
                cmp({e.tag, "_rda"}, RdDataA, e.rda);
                cmp({e.tag, "_rdb"}, RdDataB, e.rdb);
                cmp({e.tag, "_mask"}, ValidMask, e.mask);
                cmp({e.tag, "_cnt"}, {{(32-CW){1'b0}}, WrCount}, 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  wa, ra, rb;
        logic [31:0] wd;
        logic        we;
        model_reset();
        #12 Reset = 1'b0;

        // Reset state
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "reset");
        // Basic write then read
        step(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0, "wr8");
        step(1'b0, 5'd8, 32'h0, 5'd8, 5'd8, "rd8");
        // Writes to $0 are discarded
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd8, "wr0");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");
        // Link write with same-cycle read of $31
        step(1'b1, 5'd31, 32'h0040_0008, 5'd8, 5'd31, "link");
        step(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "link_after");
        // WrEn=0 leaves state untouched regardless of address/data
        step(1'b0, 5'd8, 32'h1111_1111, 5'd8, 5'd31, "wren0");
        step(1'b0, 5'd8, 32'h0, 5'd8, 5'd31, "wren0_after");

        // Async reset while a write is pending
        step(1'b1, 5'd3, 32'h0000_1234, 5'd3, 5'd3, "wr3");
        @(negedge CLK);
        WrEn = 1'b1; WrAddr = 5'd3; WrData = 32'hAAAA_5555; RdAddrA = 5'd3; RdAddrB = 5'd31;
        #1 push_check("pre_rst");
        #1 Reset = 1'b1;
        model_reset();
        #1 push_check("async_rst");
        @(posedge CLK);
        #1 push_check("rst_hold");
        @(negedge CLK);
        WrEn = 1'b0;
        Reset = 1'b0;
        #1 push_check("rst_release");

        // Counter wrap with CNT_W=4: 17 writes -> 1
        for (int i = 0; i < 17; i++)
            step(1'b1, 5'(1 + (i % 31)), 32'(i * 32'h0101_0101 + 1), 5'(1 + (i % 31)), 5'd31, "wrap_wr");
        step(1'b0, 5'd7, 32'h5, 5'd1, 5'd17, "wrap_idle1");
        step(1'b0, 5'd7, 32'h5, 5'd2, 5'd16, "wrap_idle2");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: wa = 5'd0;
                1: wa = 5'd31;
                default: wa = 5'($urandom);
            endcase
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step(we, wa, wd, ra, rb, "rand");
        end

        @(negedge CLK);
        WrEn = 1'b0;
        #1 push_check("final");
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
